// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate-block self-test sequencer.
// Optional first-failure capture is enabled with GATE_SEQ_FIRST_FAIL_EN.
package gate_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    NEXT,
    DONE
  } state_t;

  localparam int RES_W    = 7;
  localparam int RES_AND  = 0;
  localparam int RES_OR   = 1;
  localparam int RES_NOTA = 2;
  localparam int RES_NAND = 3;
  localparam int RES_NOR  = 4;
  localparam int RES_XOR  = 5;
  localparam int RES_XNOR = 6;

  // Expected gate_res for each {a,b} vector
  localparam logic [RES_W-1:0] GOLD_00 = 7'h5C;
  localparam logic [RES_W-1:0] GOLD_01 = 7'h2E;
  localparam logic [RES_W-1:0] GOLD_10 = 7'h2A;
  localparam logic [RES_W-1:0] GOLD_11 = 7'h43;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational golden truth table for the two-input gate block.
// Maps vector index {a,b} to the expected 7-bit gate result.
module gate_golden_model
  import gate_seq_pkg::*;
(
  input  logic [1:0]       idx,
  output logic [RES_W-1:0] exp
);

  always_comb begin
    exp = GOLD_00;
    unique case (idx)
      2'd0: exp = GOLD_00;
      2'd1: exp = GOLD_01;
      2'd2: exp = GOLD_10;
      2'd3: exp = GOLD_11;
      default: exp = GOLD_00;
    endcase
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Self-test sequencer: sweeps A/B over all vectors and checks gate_res.
// Define GATE_SEQ_FIRST_FAIL_EN to add first_fail_vld/first_fail_idx.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int LOOPS      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             a_out,
  output logic             b_out,
  input  logic [RES_W-1:0] gate_res,
  output logic [3:0]       err_cnt,
  output logic             pass,
  output logic [RES_W-1:0] last_res
`ifdef GATE_SEQ_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [1:0]       first_fail_idx
`endif
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
  localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);

  state_t state_q, state_d;

  logic [1:0]       idx_q, idx_d;
  logic [7:0]       loop_q, loop_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [3:0]       err_q, err_d;
  logic             pass_q, pass_d;
  logic [RES_W-1:0] res_q, res_d;

  logic [RES_W-1:0] exp_res;
  logic             accept;
  logic             mismatch;
  logic             last_vec;

  gate_golden_model u_gold (
    .idx (idx_q),
    .exp (exp_res)
  );

  assign accept   = (state_q == IDLE) && start;
  assign mismatch = (gate_res != exp_res);
  assign last_vec = (idx_q == 2'd3) && (loop_q == LOOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = SETTLE;
      SETTLE:  if (cnt_q <= 4'd1) state_d = SAMPLE;
      SAMPLE:  state_d = NEXT;
      NEXT:    state_d = last_vec ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    idx_d  = idx_q;
    loop_d = loop_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    err_d  = err_q;
    pass_d = pass_q;
    res_d  = res_q;
    unique case (state_q)
      IDLE: begin
        idx_d  = 2'd0;
        loop_d = 8'd0;
        if (start) begin
          err_d  = 4'd0;
          pass_d = 1'b0;
        end
      end
      DRIVE: begin
        a_d   = idx_q[1];
        b_d   = idx_q[0];
        cnt_d = SETTLE_LD;
      end
      SETTLE: cnt_d = cnt_q - 4'd1;
      SAMPLE: begin
        res_d = gate_res;
        if (mismatch) err_d = sat_inc4(err_q);
      end
      NEXT: begin
        if (!last_vec) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) loop_d = loop_q + 8'd1;
        end
      end
      DONE: pass_d = (err_q == 4'd0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      loop_q <= 8'd0;
      cnt_q  <= 4'd0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      err_q  <= 4'd0;
      pass_q <= 1'b0;
      res_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      loop_q <= loop_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      err_q  <= err_d;
      pass_q <= pass_d;
      res_q  <= res_d;
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign err_cnt  = err_q;
  assign pass     = pass_q;
  assign last_res = res_q;

`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic       ffv_q, ffv_d;
  logic [1:0] ffi_q, ffi_d;

  always_comb begin
    ffv_d = ffv_q;
    ffi_d = ffi_q;
    if (accept) begin
      ffv_d = 1'b0;
      ffi_d = 2'd0;
    end else if (state_q == SAMPLE && mismatch && !ffv_q) begin
      ffv_d = 1'b1;
      ffi_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ffv_q <= 1'b0;
      ffi_q <= 2'd0;
    end else begin
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
    end
  end

  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
`endif

endmodule
